// File: rtl/tmr0_peripheral.sv
// TMR0 timer/counter with 8-bit prescaler and OPTION_REG, sitting on the core register-file bus.
// Define TMR0_EXT_CLK_EN to build the t0cki external-clock path (synchronizer, edge detect, T0CS/T0SE).
module tmr0_peripheral #(
    parameter logic [8:0] TMR0_ADDR   = 9'h001,
    parameter logic [8:0] OPTION_ADDR = 9'h081
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] extern_peripherals_addr,
    input  logic [7:0] extern_peripherals_data_in,
    input  logic       extern_peripherals_wr_en,
    output logic [7:0] extern_peripherals_data_out,
    input  logic       t0cki,
    output logic       t0if_set,
    output logic [7:0] option_out
);

    logic [1:0] q_q, q_d;
    logic [7:0] tmr0_q, tmr0_d;
    logic [7:0] option_q, option_d;
    logic [7:0] psc_q, psc_d;
    logic [1:0] inhib_q, inhib_d;
    logic       t0if_q, t0if_d;

    logic       tmr0_sel, opt_sel, tmr0_wr, opt_wr;
    logic       instr_tick, ext_tick, src_tick, inc;
    logic [7:0] psc_max;
    logic       unused_ok;

    // Bank mirrors share the low 8 address bits, so bit 8 is never decoded.
    assign tmr0_sel = (extern_peripherals_addr[7:0] == TMR0_ADDR[7:0]);
    assign opt_sel  = (extern_peripherals_addr[7:0] == OPTION_ADDR[7:0]);
    assign tmr0_wr  = extern_peripherals_wr_en && tmr0_sel;
    assign opt_wr   = extern_peripherals_wr_en && opt_sel;

    always_comb begin
        extern_peripherals_data_out = 8'h00;
        if (tmr0_sel) begin
            extern_peripherals_data_out = tmr0_q;
        end else if (opt_sel) begin
            extern_peripherals_data_out = option_q;
        end
    end

    assign instr_tick = (q_q == 2'd3);
    assign t0if_set   = t0if_q;
    assign option_out = option_q;

`ifdef TMR0_EXT_CLK_EN
    logic sync1_q, sync2_q, edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= t0cki;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign ext_tick  = option_q[4] ? (~sync2_q & edge_q) : (sync2_q & ~edge_q);
    assign src_tick  = option_q[5] ? ext_tick : instr_tick;
    assign unused_ok = &{1'b0, extern_peripherals_addr[8]};
`else
    assign ext_tick  = 1'b0;
    assign src_tick  = instr_tick;
    assign unused_ok = &{1'b0, extern_peripherals_addr[8], t0cki, option_q[5:4], ext_tick};
`endif

    // Terminal prescaler count is 2^(PS+1)-1, i.e. 8'hFF shifted down by (7-PS).
    assign psc_max = 8'hFF >> (3'd7 - option_q[2:0]);

    always_comb begin
        q_d      = q_q + 2'd1;
        psc_d    = psc_q;
        tmr0_d   = tmr0_q;
        option_d = option_q;
        inhib_d  = inhib_q;
        t0if_d   = 1'b0;
        inc      = 1'b0;

        if (src_tick && (inhib_q == 2'd0)) begin
            if (option_q[3]) begin
                inc = 1'b1;
            end else if (psc_q == psc_max) begin
                psc_d = 8'h00;
                inc   = 1'b1;
            end else begin
                psc_d = psc_q + 8'd1;
            end
        end

        if (instr_tick && (inhib_q != 2'd0)) begin
            inhib_d = inhib_q - 2'd1;
        end

        // A TMR0 write overrides a coincident increment and restarts the inhibit window.
        if (tmr0_wr) begin
            tmr0_d  = extern_peripherals_data_in;
            psc_d   = 8'h00;
            inhib_d = 2'd2;
        end else if (inc) begin
            tmr0_d = tmr0_q + 8'd1;
            t0if_d = (tmr0_q == 8'hFF);
        end

        if (opt_wr) begin
            option_d = extern_peripherals_data_in;
            psc_d    = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= 2'd0;
            tmr0_q   <= 8'h00;
            option_q <= 8'hFF;
            psc_q    <= 8'h00;
            inhib_q  <= 2'd0;
            t0if_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            tmr0_q   <= tmr0_d;
            option_q <= option_d;
            psc_q    <= psc_d;
            inhib_q  <= inhib_d;
            t0if_q   <= t0if_d;
        end
    end

endmodule

// File: tb/tb_tmr0_peripheral.sv
// Scoreboard bench for tmr0_peripheral: randomized and directed bus traffic against a behavioural timer model.
module tb_tmr0_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] addr;
    logic [7:0] din;
    logic       wr;
    logic       t0cki;
    logic [7:0] dout;
    logic       t0if;
    logic [7:0] opt_out;

    tmr0_peripheral dut (
        .clk                         (clk),
        .rst                         (rst),
        .extern_peripherals_addr     (addr),
        .extern_peripherals_data_in  (din),
        .extern_peripherals_wr_en    (wr),
        .extern_peripherals_data_out (dout),
        .t0cki                       (t0cki),
        .t0if_set                    (t0if),
        .option_out                  (opt_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] opt;
        logic       t0if;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   t0if_seen = 0;

    // Behavioural model: cycle count, tick count since last prescaler clear, instruction ticks left to swallow.
    int         m_cyc;
    int         m_psc;
    int         m_inhib;
    logic [7:0] m_tmr0;
    logic [7:0] m_opt;
    logic       m_t0if;
    logic [2:0] m_hist;
    logic       pin_lvl;

    function automatic void model_reset();
        m_cyc   = 0;
        m_psc   = 0;
        m_inhib = 0;
        m_tmr0  = 8'h00;
        m_opt   = 8'hFF;
        m_t0if  = 1'b0;
        m_hist  = 3'b000;
    endfunction

    function automatic logic [7:0] exp_read(input logic [8:0] a);
        if (a[7:0] == 8'h01) return m_tmr0;
        if (a[7:0] == 8'h81) return m_opt;
        return 8'h00;
    endfunction

    function automatic void model_step(input logic [8:0] a, input logic [7:0] d, input logic w, input logic pin);
        logic instr, ext, src, wt, wo, inc;
        int   ratio;
        instr = ((m_cyc % 4) == 3);
        m_cyc = m_cyc + 1;
        ext   = m_opt[4] ? (m_hist[1] == 1'b0 && m_hist[2] == 1'b1)
                         : (m_hist[1] == 1'b1 && m_hist[2] == 1'b0);
        m_hist = {m_hist[1:0], pin};
`ifdef TMR0_EXT_CLK_EN
        src = m_opt[5] ? ext : instr;
`else
        src = instr;
`endif
        wt    = w && (a[7:0] == 8'h01);
        wo    = w && (a[7:0] == 8'h81);
        ratio = 1 << (int'(m_opt[2:0]) + 1);
        inc   = 1'b0;
        if (src && m_inhib == 0) begin
            if (m_opt[3]) begin
                inc = 1'b1;
            end else begin
                m_psc = m_psc + 1;
                if (m_psc == ratio) begin
                    m_psc = 0;
                    inc   = 1'b1;
                end
            end
        end
        if (instr && m_inhib > 0) m_inhib = m_inhib - 1;
        m_t0if = 1'b0;
        if (wt) begin
            m_tmr0  = d;
            m_psc   = 0;
            m_inhib = 2;
        end else if (inc) begin
            m_t0if = (m_tmr0 == 8'hFF);
            m_tmr0 = m_tmr0 + 8'd1;
        end
        if (wo) begin
            m_opt = d;
            m_psc = 0;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] a, input logic [7:0] d, input logic w, input logic pin);
        exp_t e;
        addr  = a;
        din   = d;
        wr    = w;
        t0cki = pin;
        e.rd   = exp_read(a);
        e.opt  = m_opt;
        e.t0if = m_t0if;
        sb.push_back(e);
        @(posedge clk);
        model_step(a, d, w, pin);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(9'h001, 8'h00, 1'b0, pin_lvl);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("data_out", dout, e.rd);
            checkOutput("option_out", opt_out, e.opt);
            checkOutput("t0if_set", {7'b0, t0if}, {7'b0, e.t0if});
        end
        if (rst === 1'b0 && t0if === 1'b1) t0if_seen = t0if_seen + 1;
    end

    initial begin
        logic [7:0] prev, start;
        int         gap;
        rst     = 1'b1;
        addr    = 9'h001;
        din     = 8'h00;
        wr      = 1'b0;
        t0cki   = 1'b0;
        pin_lvl = 1'b0;
        model_reset();
        #12;
        checkOutput("reset_tmr0", dout, 8'h00);
        checkOutput("reset_option", opt_out, 8'hFF);
        checkOutput("reset_t0if", {7'b0, t0if}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Internal source, no prescaler, wrap from FE.
        applyStimulus(9'h081, 8'h08, 1'b1, pin_lvl);
        applyStimulus(9'h001, 8'hFE, 1'b1, pin_lvl);
        t0if_seen = 0;
        idle(18);
        checkOutput("wrap_pulse_count", t0if_seen[7:0], 8'd1);

        // 1:8 prescaler gives one increment per 32 clocks.
        applyStimulus(9'h081, 8'h02, 1'b1, pin_lvl);
        applyStimulus(9'h001, 8'h00, 1'b1, pin_lvl);
        for (int k = 0; k < 2; k++) begin
            prev = dout;
            gap  = 0;
            while (dout == prev && gap < 100) begin
                idle(1);
                gap++;
            end
        end
        checkOutput("psc_1to8_period", gap[7:0], 8'd32);

        // Write coinciding with the FF->00 increment must win.
        applyStimulus(9'h081, 8'h08, 1'b1, pin_lvl);
        applyStimulus(9'h001, 8'hFF, 1'b1, pin_lvl);
        gap = 0;
        while (!((m_cyc % 4) == 3 && m_inhib == 0) && gap < 20) begin
            idle(1);
            gap++;
        end
        t0if_seen = 0;
        applyStimulus(9'h001, 8'h10, 1'b1, pin_lvl);
        checkOutput("collide_tmr0", dout, 8'h10);
        idle(2);
        checkOutput("collide_t0if", t0if_seen[7:0], 8'd0);

        // Mirrors and unmatched address.
        applyStimulus(9'h101, 8'h5A, 1'b1, pin_lvl);
        applyStimulus(9'h181, 8'h0C, 1'b1, pin_lvl);
        applyStimulus(9'h005, 8'h77, 1'b1, pin_lvl);
        checkOutput("unmatched_read", dout, 8'h00);
        applyStimulus(9'h181, 8'h00, 1'b0, pin_lvl);
        checkOutput("mirror_option", dout, 8'h0C);
        applyStimulus(9'h101, 8'h00, 1'b0, pin_lvl);
        idle(4);

        // Falling-edge external clock, 5 pulses.
        applyStimulus(9'h001, 8'h40, 1'b1, pin_lvl);
        applyStimulus(9'h081, 8'h38, 1'b1, pin_lvl);
        idle(12);
        start = dout;
        for (int p = 0; p < 5; p++) begin
            pin_lvl = 1'b1;
            idle(4);
            pin_lvl = 1'b0;
            idle(4);
        end
        idle(4);
`ifdef TMR0_EXT_CLK_EN
        checkOutput("ext_5_pulses", dout - start, 8'd5);
`endif

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            logic [8:0] a;
            logic       w;
            case ($urandom_range(0, 5))
                0: a = 9'h001;
                1: a = 9'h101;
                2: a = 9'h081;
                3: a = 9'h181;
                4: a = 9'h005;
                default: a = 9'($urandom);
            endcase
            w = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) pin_lvl = ~pin_lvl;
            applyStimulus(a, 8'($urandom), w, pin_lvl);
        end

        // Asynchronous reset in the middle of counting.
        applyStimulus(9'h081, 8'h00, 1'b1, pin_lvl);
        idle(37);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_tmr0", dout, 8'h00);
        checkOutput("async_rst_option", opt_out, 8'hFF);
        checkOutput("async_rst_t0if", {7'b0, t0if}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(12);

        wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
